fir_decim_buffer: RTL and testbench
===================================

FIR_DECIM_BUFFER -- requirements
Module: fir_decim_buffer

Interface
REQ-001: Parameter DATA_W, default 16, sample width (signed two's complement).
REQ-002: Parameter DECIM, default 4, decimation factor; SHALL be a power of two, 2..16.
REQ-003: Parameter DEPTH, default 8, output FIFO depth; SHALL be a power of two, 2..64.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst_p  input  1  reset, asynchronous and active-high.
REQ-006: ena  input  1  sample enable; input accepted only when high.
REQ-007: y_in  input  DATA_W  filtered sample from the last FIR block in the cascade (y_out of that block).
REQ-008: in_valid  input  1  y_in carries a valid sample this cycle.
REQ-009: flush  input  1  synchronous clear of phase, accumulator and FIFO.
REQ-010: clear_ovf  input  1  synchronous clear of overflow flag.
REQ-011: out_data  output  DATA_W  head-of-FIFO decimated sample (first-word-fall-through).
REQ-012: out_valid  output  1  FIFO non-empty.
REQ-013: out_ready  input  1  consumer accepts out_data when out_valid and out_ready both high.
REQ-014: fifo_count  output  log2(DEPTH)+1  number of stored entries.
REQ-015: overflow  output  1  sticky: a decimated result was dropped.

Function
REQ-016: Sample accepted on an edge iff ena=1, in_valid=1, flush=0.
REQ-017: Phase counter 0..DECIM-1 increments per accepted sample, wraps DECIM-1 -> 0; held otherwise.
REQ-018: Accumulator width DATA_W+log2(DECIM), sign-extended; phase 0 loads y_in, other phases add y_in.
REQ-019: On acceptance at phase DECIM-1, result = (acc + y_in + 2^(log2(DECIM)-1)) arithmetic-shift-right log2(DECIM), truncated to DATA_W; no saturation needed (range provably fits).
REQ-020: Result pushed into FIFO on the same edge; out_valid rises the cycle after that edge if FIFO was empty (1-cycle latency, no combinational bypass).
REQ-021: Pop occurs on an edge iff out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-022: Simultaneous push and pop: both performed, fifo_count unchanged, order preserved (also when full or 1 entry).
REQ-023: Push when full without pop: result dropped, FIFO contents unchanged, overflow set to 1.
REQ-024: Pop when empty: impossible by REQ-021; out_data value then don't-care but SHALL not be X-propagating in simulation after reset (driven 0).
REQ-025: overflow cleared only by reset or clear_ovf=1; if clear_ovf and a new drop coincide, overflow SHALL end 1.
REQ-026: flush=1: phase->0, accumulator->0, FIFO emptied (count 0, out_valid 0), sample on y_in discarded, pops ignored; overflow unaffected.
REQ-027: ena=0 does not block FIFO pops; output drains regardless of ena.
REQ-028: Read/write pointers wrap modulo DEPTH; fifo_count distinguishes full (DEPTH) from empty (0).

Reset
REQ-029: rst_p=1 immediately (no clock) sets phase 0, accumulator 0, FIFO empty, out_valid 0, out_data 0, fifo_count 0, overflow 0.
REQ-030: Reset asserted mid-accumulation or with FIFO non-empty discards all partial and stored data; first accepted sample after deassertion is phase 0.

Verification
REQ-031: Defaults, out_ready=1, y_in=100,200,300,401 consecutive -> one output 250 (1001+2>>2), out_valid one cycle after 4th sample.
REQ-032: y_in four times -32768 -> out_data -32768; four times 32767 -> 32767; inputs 1,1,1,-1 -> 1 (rounding half-up of 0.5).
REQ-033: out_ready=0, 36 continuous samples -> fifo_count reaches 8, 9th result dropped, overflow=1; then out_ready=1 drains 8 results in push order; clear_ovf -> overflow 0.
REQ-034: FIFO full, out_ready=1 on the edge of a new push -> fifo_count stays 8, no overflow.
REQ-035: Assert rst_p asynchronously after 2 samples with 3 FIFO entries -> outputs zero at once; next 4 samples yield one correct average.
REQ-036: ena=0 for 5 cycles mid-group, then resume -> phase continues, average over the 4 accepted samples only; FIFO drains during ena=0.

Source files
------------

// File: rtl/fir_decim_buffer.sv
// fir_decim_buffer: block-averaging decimator (rounded mean of DECIM samples)
// feeding a first-word-fall-through output FIFO with sticky drop flag.
module fir_decim_buffer #(
   parameter int DATA_W = 16,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 8
) (
   input  logic                        clk,
   input  logic                        rst_p,
   input  logic                        ena,
   input  logic [DATA_W-1:0]           y_in,
   input  logic                        in_valid,
   input  logic                        flush,
   input  logic                        clear_ovf,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(DEPTH):0]      fifo_count,
   output logic                        overflow
);
   localparam int SH = $clog2(DECIM);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int AW = DATA_W + SH;
   localparam logic [SH-1:0] LAST = SH'(DECIM - 1);
   localparam logic signed [AW-1:0] HALF = AW'(DECIM / 2);

   logic [SH-1:0]         r_phase;
   logic signed [AW-1:0]  r_acc;
   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic [PW-1:0]         r_wp;
   logic [PW-1:0]         r_rp;
   logic [CW-1:0]         r_cnt;
   logic                  r_ovf;
   logic                  w_acc;
   logic                  w_last;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_wr;
   logic                  w_drop;
   logic signed [AW-1:0]  w_yx;
   logic signed [AW-1:0]  w_sum;
   logic signed [AW-1:0]  w_rnd;
   logic [DATA_W-1:0]     w_res;

   assign w_acc  = ena & in_valid & ~flush;
   assign w_last = w_acc & (r_phase == LAST);
   assign w_full = r_cnt == CW'(DEPTH);
   assign w_pop  = out_valid & out_ready & ~flush;
   assign w_wr   = w_last & (~w_full | w_pop);
   assign w_drop = w_last & w_full & ~w_pop;
   assign w_yx   = {{SH{y_in[DATA_W-1]}}, y_in};
   assign w_sum  = (r_phase == '0 ? '0 : r_acc) + w_yx;
   // Sum of DECIM samples plus half an LSB cannot leave AW bits, so no guard bit
   assign w_rnd  = w_sum + HALF;
   assign w_res  = DATA_W'(w_rnd >>> SH);

   assign out_valid  = r_cnt != '0;
   assign out_data   = out_valid ? r_mem[r_rp] : '0;
   assign fifo_count = r_cnt;
   assign overflow   = r_ovf;

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         r_phase <= '0;
         r_acc   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
      end else if (flush) begin
         r_phase <= '0;
         r_acc   <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_acc) begin
            r_phase <= r_phase + 1'b1;
            r_acc   <= w_sum;
         end
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
   end

   // Storage needs no reset: reads are gated by r_cnt
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= w_res;
   end
endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb_fir_decim_buffer: randomized and directed checks against a queue-based
// model of block averaging and FIFO behaviour.
module tb_fir_decim_buffer;
   localparam int DW = 16;
   localparam int DECIM = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst_p = 1'b1;
   logic ena = 1'b0;
   logic in_valid = 1'b0;
   logic flush = 1'b0;
   logic clear_ovf = 1'b0;
   logic out_ready = 1'b0;
   logic signed [DW-1:0] y_in = '0;
   logic signed [DW-1:0] out_data;
   logic out_valid;
   logic [$clog2(DEPTH):0] fifo_count;
   logic overflow;

   int n_tot = 0;
   int n_bad = 0;
   int m_grp[$];
   int m_fifo[$];
   bit m_ovf = 1'b0;

   always #5 clk = ~clk;

   fir_decim_buffer #(.DATA_W(DW), .DECIM(DECIM), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_p(rst_p), .ena(ena), .y_in(y_in), .in_valid(in_valid),
      .flush(flush), .clear_ovf(clear_ovf), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
      .overflow(overflow)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      return a >= 0 ? a / b : -((-a + b - 1) / b);
   endfunction

   task automatic model_edge();
      bit acc, pop, push, full, drop;
      int s;
      acc = ena && in_valid && !flush;
      drop = 1'b0;
      if (flush) begin
         m_grp.delete();
         m_fifo.delete();
      end else begin
         pop  = m_fifo.size() > 0 && out_ready;
         full = m_fifo.size() == DEPTH;
         push = acc && m_grp.size() == DECIM - 1;
         s = int'(y_in);
         foreach (m_grp[i]) s += m_grp[i];
         if (pop) void'(m_fifo.pop_front());
         if (push && full && !pop) drop = 1'b1;
         else if (push) m_fifo.push_back(floor_div(s + DECIM / 2, DECIM));
         if (push) m_grp.delete();
         else if (acc) m_grp.push_back(int'(y_in));
      end
      if (drop) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".vld"}, int'(out_valid), m_fifo.size() > 0 ? 1 : 0);
      chk({tag, ".cnt"}, int'(fifo_count), m_fifo.size());
      chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
      if (m_fifo.size() > 0) chk({tag, ".data"}, int'(out_data), m_fifo[0]);
   endtask

   task automatic cyc(input bit e, input bit v, input int y, input bit r,
                      input bit f, input bit c, input string tag);
      ena = e; in_valid = v; y_in = DW'(y); out_ready = r; flush = f; clear_ovf = c;
      @(posedge clk);
      model_edge();
      #1 check_all(tag);
   endtask

   task automatic samp(input int y, input bit r, input string tag);
      cyc(1'b1, 1'b1, y, r, 1'b0, 1'b0, tag);
   endtask

   task automatic idle(input bit r, input string tag);
      cyc(1'b0, 1'b0, 0, r, 1'b0, 1'b0, tag);
   endtask

   task automatic async_reset(input string tag);
      #3 rst_p = 1'b1;
      #1;
      m_grp.delete();
      m_fifo.delete();
      m_ovf = 1'b0;
      chk({tag, ".data0"}, int'(out_data), 0);
      check_all(tag);
      #2 rst_p = 1'b0;
   endtask

   initial begin
      int thr;
      #12;
      chk("rst.data0", int'(out_data), 0);
      check_all("rst");
      rst_p = 1'b0;

      samp(100, 1'b1, "r031");
      samp(200, 1'b1, "r031");
      samp(300, 1'b1, "r031");
      chk("r031.pre", int'(out_valid), 0);
      samp(401, 1'b1, "r031");
      chk("r031.avg", int'(out_data), 250);
      chk("r031.v", int'(out_valid), 1);
      idle(1'b1, "r031");

      for (int i = 0; i < 4; i++) samp(-32768, 1'b0, "r032");
      chk("r032.min", int'(out_data), -32768);
      for (int i = 0; i < 4; i++) samp(32767, 1'b0, "r032");
      samp(1, 1'b0, "r032");
      samp(1, 1'b0, "r032");
      samp(1, 1'b0, "r032");
      samp(-1, 1'b0, "r032");
      idle(1'b1, "r032");
      chk("r032.max", int'(out_data), 32767);
      idle(1'b1, "r032");
      chk("r032.half", int'(out_data), 1);
      idle(1'b1, "r032");

      for (int i = 0; i < 36; i++) begin
         samp(int'($urandom_range(0, 65535)) - 32768, 1'b0, "r033");
         if (i == 31) chk("r033.full", int'(fifo_count), DEPTH);
      end
      chk("r033.ovf", int'(overflow), 1);
      for (int i = 0; i < DEPTH; i++) idle(1'b1, "r033d");
      chk("r033.empty", int'(fifo_count), 0);
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "r033c");
      chk("r033.clr", int'(overflow), 0);

      for (int i = 0; i < 35; i++) samp(int'($urandom_range(0, 65535)) - 32768, 1'b0, "r034");
      samp(1234, 1'b1, "r034");
      chk("r034.cnt", int'(fifo_count), DEPTH);
      chk("r034.ovf", int'(overflow), 0);
      for (int i = 0; i < DEPTH; i++) idle(1'b1, "r034d");

      for (int i = 0; i < 14; i++) samp(int'($urandom_range(0, 65535)) - 32768, 1'b0, "r035");
      chk("r035.cnt3", int'(fifo_count), 3);
      async_reset("r035r");
      samp(-7, 1'b0, "r035");
      samp(8, 1'b0, "r035");
      samp(-9, 1'b0, "r035");
      samp(20, 1'b0, "r035");
      chk("r035.avg", int'(out_data), 3);
      idle(1'b1, "r035");

      for (int i = 0; i < 8; i++) samp(int'($urandom_range(0, 2000)), 1'b0, "r036");
      samp(10, 1'b0, "r036");
      samp(20, 1'b0, "r036");
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 999, 1'b1, 1'b0, 1'b0, "r036e");
      chk("r036.drain", int'(fifo_count), 0);
      samp(30, 1'b0, "r036");
      samp(41, 1'b0, "r036");
      chk("r036.avg", int'(out_data), 25);
      idle(1'b1, "r036");

      for (int i = 0; i < 3000; i++) begin
         thr = (i / 300) % 3;
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 65535)) - 32768,
             thr == 0 ? $urandom_range(0, 7) == 0 :
             thr == 1 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 7) != 0,
             $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, "rnd");
         if (i == 1500) async_reset("rndr");
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
